// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: N producer channels in, one registered consumer stream out.
// The mux connects through the slave modport; the driving side (producers and consumer) uses master.
interface stream_mux_rr_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          selection;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_channel;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_data, in_valid, mode, selection, out_ready,
        input  in_ready, out_data, out_channel, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, selection, out_ready,
        output in_ready, out_data, out_channel, out_valid
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with a registered output stage.
// Arbitration is round-robin from the last granted channel, or a fixed channel chosen by selection.
module stream_mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input logic           clk,
    input logic           rst,
    stream_mux_rr_if.slave bus
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [WIDTH-1:0]    words [CHANNELS];
    logic [SEL_W-1:0]    last_reg;
    logic [WIDTH-1:0]    out_data_reg;
    logic [SEL_W-1:0]    out_channel_reg;
    logic                out_valid_reg;

    logic                load;
    logic                grant_any;
    logic [SEL_W-1:0]    grant_idx;
    logic [CHANNELS-1:0] grant;
    logic [WIDTH-1:0]    grant_word;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_words
            assign words[gi] = bus.in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The output register can take a new word when empty or when it is being drained this cycle.
    assign load = !out_valid_reg || bus.out_ready;

    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant      = '0;
        grant_word = '0;
        if (bus.mode) begin
            // Out-of-range selections never match any channel, so they yield no grant.
            for (int i = 0; i < CHANNELS; i++) begin
                if (SEL_W'(i) == bus.selection && bus.in_valid[i]) begin
                    grant_any = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            // Descending scans leave the lowest matching index: first those above last, then wrap.
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                if (bus.in_valid[i] && SEL_W'(i) > last_reg) begin
                    grant_any = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
            if (!grant_any) begin
                for (int i = CHANNELS - 1; i >= 0; i--) begin
                    if (bus.in_valid[i] && SEL_W'(i) <= last_reg) begin
                        grant_any = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_any && SEL_W'(i) == grant_idx) begin
                grant[i]   = 1'b1;
                grant_word = words[i];
            end
        end
    end

    assign bus.in_ready = rst ? '0 : (grant & {CHANNELS{load}});

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            out_channel_reg <= '0;
            last_reg        <= SEL_W'(CHANNELS - 1);
        end else if (load) begin
            if (grant_any) begin
                out_data_reg    <= grant_word;
                out_channel_reg <= grant_idx;
                out_valid_reg   <= 1'b1;
                if (!bus.mode) begin
                    last_reg <= grant_idx;
                end
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.out_data    = out_data_reg;
    assign bus.out_channel = out_channel_reg;
    assign bus.out_valid   = out_valid_reg;
endmodule
